// File: rtl/opsum_glb_writer.sv
// opsum_glb_writer: drains packed opsum words into GLB SRAM writes.
// Optional lane ReLU at capture when OPSUM_WRITER_RELU_EN is defined.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   start               job launch pulse (honoured only in IDLE)
//   base_addr           GLB byte address of row 0 / word 0
//   row_stride          byte distance between row bases
//   row_cnt             rows in job (0 = empty job)
//   words_per_row       words per row, 1..4 (0 acts as 1)
//   opsum_ready/data    word presented by the opsum buffer
//   opsum_valid         writer consumes the presented word this cycle
//   glb_stall           GLB cannot take a write this cycle
//   glb_we/addr/wdata   GLB write port
//   busy, done          job status, done is a one-cycle pulse
module opsum_glb_writer #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int ROW_NUM = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [5:0]        row_cnt,
  input  logic [2:0]        words_per_row,
  input  logic              opsum_ready,
  input  logic [DATA_W-1:0] opsum_data,
  output logic              opsum_valid,
  input  logic              glb_stall,
  output logic              glb_we,
  output logic [ADDR_W-1:0] glb_addr,
  output logic [DATA_W-1:0] glb_wdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [5:0] ROW_MAX = 6'(ROW_NUM);

  state_t            state;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] row_base;
  logic [5:0]        row_cnt_q;
  logic [5:0]        wr_row;
  logic [2:0]        wpr_q;
  logic [2:0]        wr_word;

  logic [5:0]        rows_in;
  logic [2:0]        wpr_in;
  logic              cap;
  logic              wr_ok;
  logic              row_end;
  logic              last_word;

  // Clamp the job shape at launch so the counters stay in range.
  assign rows_in = (row_cnt > ROW_MAX) ? ROW_MAX : row_cnt;

  always_comb begin
    wpr_in = words_per_row;
    if (words_per_row == 3'd0)
      wpr_in = 3'd1;
    else if (words_per_row > 3'd4)
      wpr_in = 3'd4;
  end

  // Pull a word whenever OREG is empty or being written this cycle.
  assign opsum_valid = (state == S_RUN) && (!glb_we || !glb_stall);
  assign cap         = opsum_valid && opsum_ready;
  assign wr_ok       = glb_we && !glb_stall;
  assign row_end     = (wr_word == wpr_q - 3'd1);
  assign last_word   = row_end && (wr_row == row_cnt_q - 6'd1);
  assign busy        = (state != S_IDLE);

  function automatic logic [DATA_W-1:0] shape(
    input logic [DATA_W-1:0] d
  );
`ifdef OPSUM_WRITER_RELU_EN
    logic [DATA_W-1:0] r;
    r = d;
    for (int i = 0; i < DATA_W / 16; i++) begin
      if (r[16*i+15])
        r[16*i +: 16] = 16'h0000;
    end
    return r;
`else
    return d;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      glb_we    <= 1'b0;
      glb_addr  <= '0;
      glb_wdata <= '0;
      done      <= 1'b0;
      stride_q  <= '0;
      row_base  <= '0;
      row_cnt_q <= '0;
      wpr_q     <= '0;
      wr_row    <= '0;
      wr_word   <= '0;
    end else begin
      done <= 1'b0;

      // OREG: a capture reloads it even if the old
      // word completes in the same cycle.
      if (cap) begin
        glb_we    <= 1'b1;
        glb_addr  <= row_base
                   + ADDR_W'({wr_word, 2'b00});
        glb_wdata <= shape(opsum_data);
        if (row_end) begin
          wr_word  <= '0;
          wr_row   <= wr_row + 6'd1;
          row_base <= row_base + stride_q;
        end else begin
          wr_word <= wr_word + 3'd1;
        end
      end else if (wr_ok) begin
        glb_we <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (rows_in == 6'd0) begin
              state <= S_DONE;
            end else begin
              stride_q  <= row_stride;
              row_base  <= base_addr;
              row_cnt_q <= rows_in;
              wpr_q     <= wpr_in;
              wr_row    <= '0;
              wr_word   <= '0;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (cap && last_word)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (wr_ok)
            state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
